// File: rtl/demux_pkg.sv
// Shared route selects and state encodings for the 1:2 stream demux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_pkg;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fsm_state_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/demux_skid_buf.sv
// Two-entry registered skid buffer carrying one beat (data plus last).
// Latency: a pushed beat is visible on out_vld_o one cycle later.
// Backpressure: in_rdy_o is registered (low only when FULL); never depends on out_rdy_i.
module demux_skid_buf
  import demux_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_dat_i,
  input  logic         in_vld_i,
  output logic         in_rdy_o,
  output logic [W-1:0] out_dat_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_rdy_o  = (state_q != FULL);
  assign out_vld_o = (state_q != EMPTY);
  assign out_dat_o = head_q;

  // The FULL guard makes a push into a full buffer impossible even if the caller misbehaves.
  assign push = in_vld_i && (state_q != FULL);
  assign pop  = out_rdy_i && (state_q != EMPTY);

  // Occupancy and slot updates; head is always the oldest beat so order stays FIFO.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_dat_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_dat_i;
        end else if (push) begin
          tail_d  = in_dat_i;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and slot registers; slots clear on reset so outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// 1:2 valid/ready stream demux with optional per-packet route locking and delivery counters.
// Latency: one cycle from input accept to the selected output valid; 1 beat/clk per path.
// Backpressure: s_ready follows the registered fill state of the selected skid buffer only.
module demux2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PKT_MODE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              sel,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              busy
);

  localparam int BW  = DATA_W + 1;
  localparam bit PKT = (PKT_MODE != 0);

  fsm_state_e       state_q, state_d;
  logic             lock_sel_q, lock_sel_d;
  logic             rdy_en_q;
  logic             esel, accept;
  logic             buf0_rdy, buf1_rdy;
  logic             push0, push1;
  logic [BW-1:0]    beat;
  logic [BW-1:0]    buf0_dat, buf1_dat;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Inside a packet the route is pinned to the sel captured on its first beat.
  assign esel    = (PKT && state_q == LOCKED) ? lock_sel_q : sel;
  // rdy_en_q holds s_ready low through reset and releases it on the first edge after.
  assign s_ready = rdy_en_q && ((esel == SEL_M1) ? buf1_rdy : buf0_rdy);
  assign accept  = s_valid && s_ready;
  assign push0   = accept && (esel == SEL_M0);
  assign push1   = accept && (esel == SEL_M1);
  assign beat    = {s_last, s_data};
  assign busy    = (state_q == LOCKED);
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

  assign {m0_last, m0_data} = buf0_dat;
  assign {m1_last, m1_data} = buf1_dat;

  demux_skid_buf #(.W(BW)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat_i  (beat),
    .in_vld_i  (push0),
    .in_rdy_o  (buf0_rdy),
    .out_dat_o (buf0_dat),
    .out_vld_o (m0_valid),
    .out_rdy_i (m0_ready)
  );

  demux_skid_buf #(.W(BW)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat_i  (beat),
    .in_vld_i  (push1),
    .in_rdy_o  (buf1_rdy),
    .out_dat_o (buf1_dat),
    .out_vld_o (m1_valid),
    .out_rdy_i (m1_ready)
  );

  // Packet FSM: lock on a non-last first beat, unlock on the accepted last beat.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (PKT && accept) begin
      case (state_q)
        IDLE: begin
          if (!s_last) begin
            state_d    = LOCKED;
            lock_sel_d = sel;
          end
        end
        LOCKED: begin
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, lock and input-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= SEL_M0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // Delivered-beat counters; wrap silently at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (m0_valid && m0_ready) cnt0_q <= cnt0_q + CNT_W'(1);
      if (m1_valid && m1_ready) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

endmodule
